// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg -- configurable UART transmitter for the config path.
//
// Takes bytes on a valid/ready handshake and sends them LSB first on
// o_Tx_Serial. The baud divisor, parity mode and stop-bit count are read at
// the start of each frame and held until that frame ends.
//
// Optional feature macro: UART_TX_FIFO_EN. When it is defined, a FIFO_DEPTH
// entry FIFO buffers the input and frames are sent back to back. When it is
// undefined, one byte is accepted only while the transmitter is idle.
//
// Ports:
//   i_Clock         clock, rising edge
//   i_Rst_n         asynchronous active-low reset
//   i_Clks_Per_Bit  clocks per serial bit (0 is treated as 1)
//   i_Parity_En     append a parity bit
//   i_Parity_Odd    1 = odd parity, 0 = even parity
//   i_Two_Stop      send two stop bits instead of one
//   i_Tx_Valid      a byte is offered on i_Tx_Data
//   o_Tx_Ready      the offered byte is taken when i_Tx_Valid is also high
//   i_Tx_Data       the byte to send
//   o_Tx_Serial     serial line, idles high
//   o_Tx_Active     high from the start bit through the last stop bit
//   o_Tx_Done       one-cycle pulse after each completed frame
//   o_Fifo_Count    number of FIFO entries in use (always 0 without the FIFO)
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int WORD       = 8,
    parameter int CLKS_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic [CLKS_WIDTH-1:0]         i_Clks_Per_Bit,
    input  logic                          i_Parity_En,
    input  logic                          i_Parity_Odd,
    input  logic                          i_Two_Stop,
    input  logic                          i_Tx_Valid,
    output logic                          o_Tx_Ready,
    input  logic [WORD-1:0]               i_Tx_Data,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int BIT_W = $clog2(WORD + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q;
    logic [CLKS_WIDTH-1:0]   clk_cnt_q;
    logic [CLKS_WIDTH-1:0]   n_m1_q;      // latched bit period minus one
    logic [BIT_W-1:0]        bit_idx_q;   // data bit index, reused as stop-bit index
    logic [WORD-1:0]         shift_q;
    logic                    par_bit_q;
    logic                    par_en_q;
    logic                    two_stop_q;
    logic                    serial_q;
    logic                    active_q;
    logic                    end_q;
    logic                    done_q;
    logic                    run_q;       // low until the first clock after reset

    logic                    bit_end;
    logic                    frame_end;
    logic                    start_frame;
    logic [WORD-1:0]         start_data;
    logic [CLKS_WIDTH-1:0]   clks_m1;
    logic                    line_d;

    assign bit_end   = (clk_cnt_q == n_m1_q);
    assign frame_end = (state_q == ST_STOP) && bit_end &&
                       (bit_idx_q == BIT_W'(two_stop_q));
    assign clks_m1   = (i_Clks_Per_Bit == '0) ? '0 : i_Clks_Per_Bit - CLKS_WIDTH'(1);

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WORD-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign push = i_Tx_Valid & o_Tx_Ready;
    // Pop while idle, or on the last stop-bit cycle so the next start bit follows with no gap.
    assign pop  = (count_q != '0) && ((state_q == ST_IDLE) || frame_end);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_Tx_Data;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    assign start_frame  = pop;
    assign start_data   = mem_q[rd_ptr_q];
    assign o_Tx_Ready   = ready_q & run_q;
    assign o_Fifo_Count = count_q;
`else
    assign o_Tx_Ready   = run_q & (state_q == ST_IDLE);
    assign start_frame  = (state_q == ST_IDLE) & i_Tx_Valid & o_Tx_Ready;
    assign start_data   = i_Tx_Data;
    assign o_Fifo_Count = '0;
`endif

    // NOTE: every output of an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = par_bit_q;
            default:   line_d = 1'b1;
        endcase
    end

    // The line and status flags are registered from the current state, so they
    // trail the state by one cycle. Done waits one cycle more so that it lands
    // in the cycle after the last stop bit is visible on the line.
    // NOTE: state is updated with non-blocking assignments only, so all regs see the pre-edge values.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            n_m1_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            end_q      <= 1'b0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            serial_q <= line_d;
            active_q <= (state_q != ST_IDLE);
            end_q    <= frame_end;
            done_q   <= end_q;

            if (start_frame) begin
                state_q    <= ST_START;
                clk_cnt_q  <= '0;
                bit_idx_q  <= '0;
                shift_q    <= start_data;
                par_bit_q  <= (^start_data) ^ i_Parity_Odd;
                n_m1_q     <= clks_m1;
                par_en_q   <= i_Parity_En;
                two_stop_q <= i_Two_Stop;
            end else if (state_q != ST_IDLE) begin
                if (!bit_end) begin
                    clk_cnt_q <= clk_cnt_q + CLKS_WIDTH'(1);
                end else begin
                    clk_cnt_q <= '0;
                    unique case (state_q)
                        ST_START: state_q <= ST_DATA;
                        ST_DATA: begin
                            shift_q <= shift_q >> 1;
                            if (bit_idx_q == BIT_W'(WORD - 1)) begin
                                bit_idx_q <= '0;
                                state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BIT_W'(1);
                            end
                        end
                        ST_PARITY: state_q <= ST_STOP;
                        ST_STOP: begin
                            if (frame_end) state_q <= ST_IDLE;
                            else           bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg -- self-checking bench for uart_tx_cfg in its default build
// (no FIFO). Expected line waveforms come from a frame model that lists the
// bits of a frame and repeats each one for the bit period.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] clks = 16'd4;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.WORD(8), .CLKS_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Clks_Per_Bit (clks),
        .i_Parity_En    (par_en),
        .i_Parity_Odd   (par_odd),
        .i_Two_Stop     (two_stop),
        .i_Tx_Valid     (tx_valid),
        .o_Tx_Ready     (tx_ready),
        .i_Tx_Data      (tx_data),
        .o_Tx_Serial    (tx_serial),
        .o_Tx_Active    (tx_active),
        .o_Tx_Done      (tx_done),
        .o_Fifo_Count   (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: start, 8 data bits LSB first, optional parity, 1 or 2 stops,
    // each held for max(n,1) cycles.
    task automatic build_wave(input logic [7:0] d, input int n, input bit pe, input bit po,
                              input bit ts);
        bit bits[$];
        int reps;
        reps = (n == 0) ? 1 : n;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (pe) bits.push_back(bit'(($countones(d) + (po ? 1 : 0)) % 2));
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[k]) for (int r = 0; r < reps; r++) exp_q.push_back(bits[k]);
    endtask

    // Offer a byte and return just after the edge that accepted it.
    task automatic offer(input logic [7:0] d, input string tag);
        bit got;
        got = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) got = 1'b1;
        end
        if (!got) check({tag, "/ready_timeout"}, tx_ready, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Follow one frame on the line. Optionally scramble the config inputs
    // mid-frame and/or offer the next byte so it is accepted as soon as possible.
    task automatic expect_frame(input logic [7:0] d, input int n, input bit pe, input bit po,
                                input bit ts, input string tag, input bit skip_pre,
                                input int change_at, input int new_n, input bit chain,
                                input logic [7:0] next_d);
        int f;
        int bad;
        int bad_ctl;
        build_wave(d, n, pe, po, ts);
        f = exp_q.size();
        if (!skip_pre) begin
            @(negedge clk);
            check({tag, "/pre_line"}, tx_serial, 1);
            check({tag, "/pre_active"}, tx_active, 0);
        end
        bad = 0;
        bad_ctl = 0;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            if (tx_serial !== exp_q[i]) bad++;
            if (tx_active !== 1'b1 || tx_done !== 1'b0) bad_ctl++;
            // Ready comes back only once the final stop bit is on the line.
            if (tx_ready !== (i == f - 1)) bad_ctl++;
            if (i == change_at) begin
                clks     = 16'(new_n);
                par_en   = 1'($urandom_range(0, 1));
                par_odd  = 1'($urandom_range(0, 1));
                two_stop = 1'($urandom_range(0, 1));
            end
            if (chain && i == f - 2) begin
                tx_data  = next_d;
                tx_valid = 1'b1;
            end
        end
        check({tag, "/wave_errors"}, bad, 0);
        check({tag, "/ctl_errors"}, bad_ctl, 0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        check({tag, "/done_pulse"}, tx_done, 1);
        check({tag, "/active_fall"}, tx_active, 0);
        check({tag, "/gap_line"}, tx_serial, 1);
    endtask

    task automatic send(input logic [7:0] d, input string tag, input int change_at,
                        input int new_n);
        int n;
        bit pe, po, ts;
        n  = int'(clks);
        pe = par_en;
        po = par_odd;
        ts = two_stop;
        offer(d, tag);
        expect_frame(d, n, pe, po, ts, tag, 1'b0, change_at, new_n, 1'b0, 8'h00);
        @(negedge clk);
        check({tag, "/done_single"}, tx_done, 0);
    endtask

    initial begin
        int n;
        int bad;
        bit pe, po, ts;
        logic [7:0] a, b;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst/serial", tx_serial, 1);
        check("rst/active", tx_active, 0);
        check("rst/done", tx_done, 0);
        check("rst/ready", tx_ready, 0);
        check("rst/fifo_count", fifo_count, 0);
        #2 rst_n = 1'b1;

        // Basic frame: N=4, no parity, one stop, 0xA5.
        clks = 16'd4; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        send(8'hA5, "t1", -1, 0);

        // Parity even / odd with two stops, N=3, 0x07.
        clks = 16'd3; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b1;
        send(8'h07, "t2_even", -1, 0);
        par_odd = 1'b1;
        send(8'h07, "t2_odd", -1, 0);

        // Bit-period change mid-frame: current frame keeps 4, next uses 8.
        clks = 16'd4; par_en = 1'b0; two_stop = 1'b0;
        send(8'h5A, "t3_cur", 10, 8);
        send(8'hE1, "t3_next", -1, 0);

        // Divisor boundaries: 0 behaves as 1, and 1.
        clks = 16'd0; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
        send(8'h81, "n_zero", -1, 0);
        clks = 16'd1; par_odd = 1'b1; two_stop = 1'b1;
        send(8'h3E, "n_one", -1, 0);

        // Reset during data bit 3 (bit 3 of 0xC3 is 0, so the line visibly jumps high).
        clks = 16'd4; par_en = 1'b0; two_stop = 1'b0;
        offer(8'hC3, "t4");
        repeat (1 + 18) @(negedge clk);
        check("t4/line_before_rst", tx_serial, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t4/rst_line", tx_serial, 1);
        check("t4/rst_active", tx_active, 0);
        check("t4/rst_done", tx_done, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_serial !== 1'b1) bad++;
        end
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_serial !== 1'b1 || tx_active !== 1'b0) bad++;
        end
        check("t4/quiet_after_rst", bad, 0);
        send(8'h3C, "t4_after", -1, 0);

        // Back-to-back without FIFO: exactly one idle cycle between frames.
        clks = 16'd2; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
        a = 8'h96; b = 8'h4B;
        n = int'(clks); pe = par_en; po = par_odd; ts = two_stop;
        offer(a, "t6a");
        expect_frame(a, n, pe, po, ts, "t6a", 1'b0, -1, 0, 1'b1, b);
        expect_frame(b, n, pe, po, ts, "t6b", 1'b1, -1, 0, 1'b0, 8'h00);
        @(negedge clk);
        check("t6b/done_single", tx_done, 0);

        // Randomized frames with randomized configuration.
        for (int t = 0; t < 8; t++) begin
            clks     = 16'($urandom_range(0, 5));
            par_en   = 1'($urandom_range(0, 1));
            par_odd  = 1'($urandom_range(0, 1));
            two_stop = 1'($urandom_range(0, 1));
            send(8'($urandom_range(0, 255)), $sformatf("rnd%0d", t),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
